// File: rtl/scan_sequencer.sv
// Frame/line firing scheduler feeding Transmit: walks lines x focus zones, emitting gate windows.
// Optional macro SCAN_INTERLEAVE_EN selects even-then-odd line order within a frame.
module scan_sequencer #(
  parameter int unsigned LINE_COUNT  = 256,
  parameter int unsigned FOCUS_COUNT = 3,
  parameter int unsigned PR_CYCLES   = 200,
  parameter int unsigned RX_CYCLES   = 4000,
  parameter int unsigned END_CYCLES  = 20,
  parameter int unsigned GAP_CYCLES  = 100
) (
  input  logic       clk_100M,
  input  logic       reset_n,
  input  logic       scan_en,
  output logic [7:0] Line_Num,
  output logic [1:0] Focus_Num,
  output logic       Pr_Gate,
  output logic       RX_Gate,
  output logic       End_Gate,
  output logic       Envelop,
  output logic       Frame_Sync,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StPrep, StRx, StEndp, StGap} state_e;

  localparam logic [15:0] PrLoad    = 16'(PR_CYCLES - 1);
  localparam logic [15:0] RxLoad    = 16'(RX_CYCLES - 1);
  localparam logic [15:0] EndLoad   = 16'(END_CYCLES - 1);
  localparam logic [15:0] GapLoad   = 16'(GAP_CYCLES - 1);
  localparam logic [1:0]  FocusLast = 2'(FOCUS_COUNT - 1);

  state_e      state_q;
  logic [15:0] phase_q;
  logic [7:0]  line_q;
  logic [1:0]  focus_q;
  logic        pr_q, rx_q, end_q, env_q, fs_q, busy_q;

  logic [7:0]  line_d;
  logic [1:0]  focus_d;
  logic        focus_wrap, line_last, frame_end;

`ifdef SCAN_INTERLEAVE_EN
  logic [8:0] line_p2;
  logic       pass_end;

  // Stepping by two; overrunning the even pass restarts at line 1, overrunning the odd pass ends
  // the frame (a single-line frame ends after line 0).
  always_comb begin
    line_p2   = {1'b0, line_q} + 9'd2;
    pass_end  = (line_p2 >= 9'(LINE_COUNT));
    line_last = pass_end && (line_q[0] || (LINE_COUNT == 1));
    line_d    = pass_end ? 8'd1 : line_p2[7:0];
  end
`else
  localparam logic [7:0] LineLast = 8'(LINE_COUNT - 1);

  always_comb begin
    line_last = (line_q == LineLast);
    line_d    = line_q + 8'd1;
  end
`endif

  always_comb begin
    focus_wrap = (focus_q == FocusLast);
    frame_end  = focus_wrap && line_last;
    focus_d    = focus_wrap ? 2'd0 : focus_q + 2'd1;
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      line_q  <= '0;
      focus_q <= '0;
      pr_q    <= 1'b0;
      rx_q    <= 1'b0;
      end_q   <= 1'b0;
      env_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (scan_en) begin
            state_q <= StPrep;
            phase_q <= PrLoad;
            pr_q    <= 1'b1;
            env_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StPrep: begin
          if (phase_q == '0) begin
            state_q <= StRx;
            phase_q <= RxLoad;
            pr_q    <= 1'b0;
            rx_q    <= 1'b1;
          end else begin
            phase_q <= phase_q - 16'd1;
          end
        end
        StRx: begin
          if (phase_q == '0) begin
            state_q <= StEndp;
            phase_q <= EndLoad;
            rx_q    <= 1'b0;
            end_q   <= 1'b1;
          end else begin
            phase_q <= phase_q - 16'd1;
          end
        end
        StEndp: begin
          if (phase_q == '0) begin
            state_q <= StGap;
            phase_q <= GapLoad;
            end_q   <= 1'b0;
            env_q   <= 1'b0;
          end else begin
            phase_q <= phase_q - 16'd1;
          end
        end
        StGap: begin
          if (phase_q == '0) begin
            fs_q <= frame_end;
            if (scan_en) begin
              state_q <= StPrep;
              phase_q <= PrLoad;
              pr_q    <= 1'b1;
              env_q   <= 1'b1;
              focus_q <= focus_d;
              if (focus_wrap) line_q <= frame_end ? 8'd0 : line_d;
            end else begin
              // Stopping abandons any partial frame so the next start is at (0,0).
              state_q <= StIdle;
              phase_q <= '0;
              line_q  <= '0;
              focus_q <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            phase_q <= phase_q - 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          phase_q <= '0;
          pr_q    <= 1'b0;
          rx_q    <= 1'b0;
          end_q   <= 1'b0;
          env_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Line_Num   = line_q;
  assign Focus_Num  = focus_q;
  assign Pr_Gate    = pr_q;
  assign RX_Gate    = rx_q;
  assign End_Gate   = end_q;
  assign Envelop    = env_q;
  assign Frame_Sync = fs_q;
  assign busy       = busy_q;

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream timing master for the Transmit block. Walks every line (0..LINE_COUNT-1) and every focus zone (0..FOCUS_COUNT-1).
- For each firing it produces Line_Num, Focus_Num, Pr_Gate, RX_Gate, End_Gate and Envelop.
- Replaces the behavioural test model as the synthesizable frame/line scheduler feeding Transmit.

Parameters:
LINE_COUNT, 256, lines per frame (1..256)
FOCUS_COUNT, 3, focus zones per line (1..4)
PR_CYCLES, 200, Pr_Gate high time in clk_100M cycles (1..65535)
RX_CYCLES, 4000, RX_Gate high time in cycles (1..65535)
END_CYCLES, 20, End_Gate high time in cycles (1..65535)
GAP_CYCLES, 100, dead time between firings in cycles (1..65535)

Ports:
clk_100M  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous active-low reset
scan_en  in  1  level; high = run frames continuously
Line_Num  out  8  current line index
Focus_Num  out  2  current focus index
Pr_Gate  out  1  prepare window for Transmit
RX_Gate  out  1  transmit/receive window
End_Gate  out  1  end-of-firing window
Envelop  out  1  high from Pr_Gate rise through End_Gate fall
Frame_Sync  out  1  one-cycle pulse at frame completion
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. Line/focus counters 0. Phase counter 0.
- All outputs are registered. No combinational path from scan_en to any output.
- States: IDLE -> PREP -> RX -> ENDP -> GAP -> (PREP | IDLE).
- IDLE: outputs low. scan_en sampled high -> PREP on next edge. Counters are 0 on entry to PREP.
- PREP: Pr_Gate=1 for exactly PR_CYCLES cycles, then RX.
- RX: RX_Gate=1 for exactly RX_CYCLES cycles, then ENDP.
- ENDP: End_Gate=1 for exactly END_CYCLES cycles, then GAP.
- Gates are mutually exclusive. Each gate rises on the same edge the previous gate falls (no overlap, no hole).
- Envelop=1 in PREP, RX and ENDP. It is a single contiguous pulse of PR_CYCLES+RX_CYCLES+END_CYCLES cycles.
- GAP: all gates low for GAP_CYCLES cycles.
- GAP exit advances the indices:
  - Focus_Num+1.
  - If Focus_Num==FOCUS_COUNT-1: Focus_Num=0 and Line_Num+1.
  - If Line_Num==LINE_COUNT-1 as well: Line_Num=0 and Frame_Sync=1 for one cycle, coincident with the index update.
- Line_Num/Focus_Num change only on GAP exit or reset. They are stable throughout PREP..GAP of a firing.
- GAP exit target:
  - scan_en=1 -> PREP.
  - scan_en=0 -> IDLE, and line/focus reset to 0. A partial frame is abandoned; the next start begins at line 0, focus 0.
- scan_en deasserting mid-firing does not truncate gates. The current firing completes through GAP.
- Phase counter: 16-bit, loaded with N-1 on state entry, decremented; state exits at 0. A value of 1 yields exactly 1 cycle.
- busy=1 from the PREP entry edge until the IDLE entry edge.
- Firing period = PR+RX+END+GAP cycles. Frame = LINE_COUNT*FOCUS_COUNT firings, with no extra inter-frame gap.
- Async reset mid-firing: all gates drop immediately (asynchronously). The sequence restarts from IDLE.

Optional Feature:
- Macro: SCAN_INTERLEAVE_EN.
- Defined: line order within a frame is all even lines ascending, then all odd lines ascending (e.g. 0,2,...,254,1,3,...,255).
  - Frame_Sync fires after the last odd line.
  - If LINE_COUNT is odd, the even pass ends at LINE_COUNT-1, then the odd pass starts at 1.
  - LINE_COUNT=1 fires line 0 only.
- Undefined: sequential order 0..LINE_COUNT-1. No interleave logic is synthesized.

Test Plan:
1. Params PR=2,RX=3,END=1,GAP=2,LINES=2,FOCUS=2; reset, then scan_en=1 -> Pr_Gate 2 cycles, RX_Gate 3, End_Gate 1, Envelop 6, 2 idle cycles; Line/Focus sequence (0,0),(0,1),(1,0),(1,1),(0,0); Frame_Sync one pulse per 32 cycles.
2. Same params, drop scan_en during RX of firing (0,1) -> RX and End complete full length, GAP completes, IDLE, busy=0, indices return to 0; re-enable -> next firing is (0,0).
3. All cycle parameters =1, FOCUS=1, LINES=3 -> 4-cycle period, Line_Num 0,1,2,0, gates never overlap, Frame_Sync every 12 cycles.
4. Assert reset_n=0 asynchronously mid-PREP -> Pr_Gate, Envelop, busy drop before the next clock edge; after release with scan_en=1, firing restarts at (0,0).
5. Defaults LINE_COUNT=256, FOCUS_COUNT=3 -> Line_Num wraps 255->0 with Frame_Sync after exactly 768 firings; Focus_Num never reaches 3.
6. SCAN_INTERLEAVE_EN, LINES=5, FOCUS=1 -> line order 0,2,4,1,3, then Frame_Sync, then 0.
